// File: rtl/imem_fill_check_master.sv
// imem_fill_check_master: Avalon-MM master that writes base+i <= seed+i
// (FILL) or reads the same range back and counts mismatches (CHECK).
module imem_fill_check_master #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   word_count,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_chipselect,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid
);
    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FINISH} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] cmd_idx;
    logic [ADDR_W-1:0] rsp_idx;
    logic [DATA_W-1:0] seed_q;
    logic [3:0]        outstanding;

    logic              wr_acc;
    logic              rd_acc;
    logic              rsp_vld;
    logic              mismatch;
    logic [ADDR_W-1:0] cmd_nx;
    logic [ADDR_W-1:0] rsp_nx;
    logic [ADDR_W-1:0] rd_issued;
    logic [3:0]        out_nx;

    assign avm_byteenable = '1;
    assign avm_chipselect = avm_read | avm_write;

    assign wr_acc    = avm_write & ~avm_waitrequest;
    assign rd_acc    = avm_read & ~avm_waitrequest;
    // Responses only count while a read run owns the bus and one is pending
    assign rsp_vld   = avm_readdatavalid && (outstanding != 4'd0) &&
                       (state == READ || state == DRAIN);
    assign cmd_nx    = cmd_idx + ADDR_W'(1);
    assign rsp_nx    = rsp_vld ? rsp_idx + ADDR_W'(1) : rsp_idx;
    assign rd_issued = rd_acc ? cmd_nx : cmd_idx;
    assign mismatch  = rsp_vld &&
                       (avm_readdata != seed_q + DATA_W'(rsp_idx));

    always_comb begin
        out_nx = outstanding;
        if (rd_acc && !rsp_vld)
            out_nx = outstanding + 4'd1;
        else if (!rd_acc && rsp_vld)
            out_nx = outstanding - 4'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            base_q         <= '0;
            count_q        <= '0;
            seed_q         <= '0;
            cmd_idx        <= '0;
            rsp_idx        <= '0;
            outstanding    <= '0;
        end else begin
            done        <= 1'b0;
            outstanding <= out_nx;
            rsp_idx     <= rsp_nx;
            if (mismatch) begin
                if (err_count != 16'hFFFF)
                    err_count <= err_count + 16'd1;
                if (err_count == 16'd0)
                    first_err_addr <= base_q + rsp_idx;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        base_q         <= base_addr;
                        count_q        <= word_count;
                        seed_q         <= seed;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        cmd_idx        <= '0;
                        rsp_idx        <= '0;
                        outstanding    <= '0;
                        avm_address    <= base_addr;
                        avm_writedata  <= seed;
                        if (word_count == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else if (mode) begin
                            state    <= READ;
                            busy     <= 1'b1;
                            avm_read <= 1'b1;
                        end else begin
                            state     <= WRITE;
                            busy      <= 1'b1;
                            avm_write <= 1'b1;
                        end
                    end
                end

                WRITE: begin
                    if (wr_acc) begin
                        cmd_idx <= cmd_nx;
                        if (cmd_nx == count_q) begin
                            avm_write <= 1'b0;
                            state     <= FINISH;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            avm_address   <= base_q + cmd_nx;
                            avm_writedata <= seed_q + DATA_W'(cmd_nx);
                        end
                    end
                end

                READ: begin
                    if (rd_acc)
                        cmd_idx <= cmd_nx;
                    if (rd_acc && cmd_nx == count_q) begin
                        avm_read <= 1'b0;
                        state    <= DRAIN;
                    end else if (!avm_read || rd_acc) begin
                        // Re-arm only when the pipeline has room after this edge
                        avm_read    <= (out_nx < MAX_OUT);
                        avm_address <= base_q + rd_issued;
                    end
                end

                DRAIN: begin
                    if (out_nx == 4'd0 && rsp_nx == count_q) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_fill_check_master.sv
// Bench for imem_fill_check_master: Avalon slave model with memory,
// random waitrequest, fixed read latency and command scoreboards.
module tb_imem_fill_check_master;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] word_count = '0;
    logic [DW-1:0] seed = '0;
    logic          busy;
    logic          done;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic [AW-1:0] avm_address;
    logic [DW/8-1:0] avm_byteenable;
    logic          avm_chipselect;
    logic          avm_read;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic          avm_waitrequest = 1'b0;
    logic [DW-1:0] avm_readdata = '0;
    logic          avm_readdatavalid = 1'b0;

    always #5 clk = ~clk;

    imem_fill_check_master #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .mode(mode),
        .base_addr(base_addr),
        .word_count(word_count),
        .seed(seed),
        .busy(busy),
        .done(done),
        .err_count(err_count),
        .first_err_addr(first_err_addr),
        .avm_address(avm_address),
        .avm_byteenable(avm_byteenable),
        .avm_chipselect(avm_chipselect),
        .avm_read(avm_read),
        .avm_write(avm_write),
        .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    bit   [DW-1:0]    mem [0:65535];
    rsp_t             pipe[$];
    logic [AW+DW-1:0] exp_wr[$];
    logic [AW-1:0]    exp_rd[$];

    int cyc = 0, lat = 1, wait_pct = 0;
    int outst = 0, max_out = 0, n_rsp = 0, n_done = 0;
    int done_cyc = 0, start_cyc = 0, first_acc = -1;
    int last_acc = 0, last_rsp = 0;
    logic          prev_stall = 1'b0;
    logic          prev_rd = 1'b0, prev_wr = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;

    // Observe the bus on the rising edge using pre-edge values
    always @(posedge clk) begin : mon
        logic [AW+DW-1:0] e;
        cyc++;
        if (!reset_n) begin
            outst = 0;
            prev_stall = 1'b0;
        end else begin
            if (start && !busy)
                start_cyc = cyc;
            if (prev_stall)
                chk("stall_hold",
                    {avm_read, avm_write, avm_address, avm_writedata},
                    {prev_rd, prev_wr, prev_addr, prev_data});
            if (avm_read || avm_write) begin
                chk("rd_wr_excl", avm_read & avm_write, 0);
                chk("chipselect", avm_chipselect, 1);
                chk("byteenable", avm_byteenable, 4'hF);
            end
            if (avm_write && !avm_waitrequest) begin
                chk("wr_queued", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_cmd", {avm_address, avm_writedata}, e);
                end
                mem[avm_address] = avm_writedata;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (avm_read && !avm_waitrequest) begin
                chk("rd_queued", exp_rd.size() > 0, 1);
                if (exp_rd.size() > 0)
                    chk("rd_addr", avm_address, exp_rd.pop_front());
                pipe.push_back('{due: cyc + lat - 1,
                                 data: mem[avm_address]});
                outst++;
                if (outst > max_out) max_out = outst;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (avm_readdatavalid) begin
                if (outst > 0) outst--;
                n_rsp++;
                last_rsp = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                chk("busy_at_done", busy, 0);
            end
            prev_stall = (avm_read | avm_write) & avm_waitrequest;
            prev_rd = avm_read;
            prev_wr = avm_write;
            prev_addr = avm_address;
            prev_data = avm_writedata;
        end
    end

    // Slave drives its outputs on the falling edge
    always @(negedge clk) begin : drv
        rsp_t r;
        avm_waitrequest = (wait_pct > 0) &&
                          ($urandom_range(99) < wait_pct);
        if (pipe.size() > 0 && pipe[0].due <= cyc) begin
            r = pipe.pop_front();
            avm_readdatavalid = 1'b1;
            avm_readdata = r.data;
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata = '0;
        end
    end

    task automatic run(input string tag, input logic m,
                       input logic [AW-1:0] b, input logic [AW-1:0] n,
                       input logic [DW-1:0] s, input bit poke);
        int            e_err;
        logic [AW-1:0] e_first;
        logic [AW-1:0] a;
        int            t;
        e_err = 0;
        e_first = '0;
        n_done = 0;
        n_rsp = 0;
        max_out = 0;
        first_acc = -1;
        for (int i = 0; i < int'(n); i++) begin
            a = b + AW'(i);
            if (!m) begin
                exp_wr.push_back({a, s + DW'(i)});
            end else begin
                exp_rd.push_back(a);
                if (mem[a] != s + DW'(i)) begin
                    if (e_err == 0) e_first = a;
                    e_err++;
                end
            end
        end
        @(negedge clk);
        start = 1'b1;
        mode = m;
        base_addr = b;
        word_count = n;
        seed = s;
        @(negedge clk);
        start = 1'b0;
        mode = ~m;
        base_addr = ~b;
        word_count = n + 16'd5;
        seed = ~s;
        if (poke) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        t = 0;
        while (n_done == 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done_seen"}, n_done > 0, 1);
        repeat (3) @(negedge clk);
        chk({tag, "_done_once"}, n_done, 1);
        chk({tag, "_busy_idle"}, busy, 0);
        chk({tag, "_err"}, err_count, e_err);
        chk({tag, "_first"}, first_err_addr, e_first);
        chk({tag, "_wr_left"}, exp_wr.size(), 0);
        chk({tag, "_rd_left"}, exp_rd.size(), 0);
        if (n == '0) begin
            chk({tag, "_z_done_cyc"}, done_cyc, start_cyc + 1);
            chk({tag, "_z_no_bus"}, first_acc, -1);
        end else if (m) begin
            chk({tag, "_rsp_cnt"}, n_rsp, int'(n));
            chk({tag, "_drain_done"}, done_cyc, last_rsp + 1);
        end else begin
            chk({tag, "_fill_done"}, done_cyc, last_acc + 1);
        end
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_count, 0);
        chk("rst_first", first_err_addr, 0);
        chk("rst_strobes", {avm_read, avm_write, avm_chipselect}, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_wdata", avm_writedata, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        lat = 1;
        wait_pct = 0;
        run("fill10", 1'b0, 16'h0010, 16'd4, 32'hA000_0000, 1'b0);
        chk("fill10_first_cyc", first_acc, start_cyc + 1);
        chk("fill10_last_cyc", last_acc, start_cyc + 4);
        chk("fill10_mem13", mem[16'h0013], 32'hA000_0003);

        run("chk10", 1'b1, 16'h0010, 16'd4, 32'hA000_0000, 1'b0);
        chk("chk10_err_k", err_count, 16'd0);
        chk("chk10_first_k", first_err_addr, 16'h0000);

        mem[16'h0012] = '0;
        run("chk12bad", 1'b1, 16'h0010, 16'd4, 32'hA000_0000, 1'b0);
        chk("chk12bad_err_k", err_count, 16'd1);
        chk("chk12bad_first_k", first_err_addr, 16'h0012);

        wait_pct = 40;
        run("fillwrap", 1'b0, 16'hFFFE, 16'd4, 32'h5555_0000, 1'b1);
        chk("fillwrap_m0", mem[16'h0000], 32'h5555_0002);
        chk("fillwrap_m1", mem[16'h0001], 32'h5555_0003);
        chk("fillwrap_mff", mem[16'hFFFF], 32'h5555_0001);

        wait_pct = 0;
        run("fill100", 1'b0, 16'h0100, 16'd20, 32'h1234_0000, 1'b0);
        lat = 6;
        run("chk100", 1'b1, 16'h0100, 16'd20, 32'h1234_0000, 1'b1);
        chk("chk100_maxout", max_out, MO);
        chk("chk100_err_k", err_count, 16'd0);

        mem[16'h0105] = '0;
        mem[16'h010A] = 32'h1;
        lat = 3;
        wait_pct = 30;
        run("chk2bad", 1'b1, 16'h0100, 16'd20, 32'h1234_0000, 1'b0);
        chk("chk2bad_err_k", err_count, 16'd2);
        chk("chk2bad_first_k", first_err_addr, 16'h0105);

        lat = 6;
        wait_pct = 0;
        for (int i = 0; i < 20; i++)
            exp_rd.push_back(16'h0200 + AW'(i));
        @(negedge clk);
        start = 1'b1;
        mode = 1'b1;
        base_addr = 16'h0200;
        word_count = 16'd20;
        seed = 32'h0;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (outst != 3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("mid_outst3", outst, 3);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_strobes", {avm_read, avm_write, avm_chipselect}, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        n_done = 0;
        exp_rd.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_no_done", n_done, 0);
        chk("mid_err_zero", err_count, 0);
        run("zero", 1'b1, 16'h0300, 16'd0, 32'h0, 1'b0);
        repeat (10) @(negedge clk);
        chk("late_rsp_err", err_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_fill_check_master.md
IMEM_FILL_CHECK_MASTER -- requirements
Module: imem_fill_check_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width (byteenable width = DATA_W/8).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, read-pipeline depth limit (1..15).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle command strobe.
REQ-007 SHALL have port mode  input  1  0 = FILL (write), 1 = CHECK (read/compare); sampled with start.
REQ-008 SHALL have port base_addr  input  ADDR_W  first word address; sampled with start.
REQ-009 SHALL have port word_count  input  ADDR_W  number of words; sampled with start.
REQ-010 SHALL have port seed  input  DATA_W  pattern seed; sampled with start.
REQ-011 SHALL have port busy  output  1  high from start acceptance until done.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err_count  output  16  CHECK mismatch count.
REQ-014 SHALL have port first_err_addr  output  ADDR_W  address of first mismatch.
REQ-015 SHALL have Avalon-MM master ports avm_address (out, ADDR_W), avm_byteenable (out, DATA_W/8), avm_chipselect, avm_read, avm_write (out, 1), avm_writedata (out, DATA_W), avm_waitrequest (in, 1), avm_readdata (in, DATA_W), avm_readdatavalid (in, 1).

Function
REQ-016 SHALL implement states IDLE, WRITE, READ, DRAIN, FINISH.
REQ-017 SHALL accept start only in IDLE; start while busy is ignored.
REQ-018 On accepted start at edge N: latch inputs, clear err_count and first_err_addr, busy=1 and first command on bus in cycle N+1.
REQ-019 Pattern word i (0-based) SHALL be seed + i, modulo 2^DATA_W; address i SHALL be base_addr + i, modulo 2^ADDR_W (wrap-around).
REQ-020 avm_byteenable SHALL be all ones; avm_chipselect = avm_read | avm_write; never read and write together.
REQ-021 While avm_waitrequest=1, address, writedata and strobes SHALL hold stable; command counts as accepted on an edge with strobe=1 and waitrequest=0.
REQ-022 WRITE: one write per cycle when not stalled; after word_count-th acceptance go to FINISH.
REQ-023 READ: issue read only while outstanding < MAX_OUTSTANDING; after last read accepted go to DRAIN.
REQ-024 Outstanding counter: +1 on read acceptance, -1 on avm_readdatavalid, unchanged when both in same cycle.
REQ-025 Returned data SHALL be compared in order against pattern index maintained by a separate response counter.
REQ-026 Mismatch: err_count +1, saturating at 16'hFFFF; first_err_addr captured only on first mismatch of the run.
REQ-027 DRAIN: go to FINISH in cycle after outstanding reaches 0 and all word_count responses received.
REQ-028 FINISH: done=1 for exactly one cycle, busy=0 same cycle, then IDLE.
REQ-029 word_count=0: no bus transaction; FINISH in cycle N+1, err_count=0.
REQ-030 avm_readdatavalid while not in READ/DRAIN SHALL be ignored.
REQ-031 err_count and first_err_addr SHALL hold their values after done until next accepted start.

Reset
REQ-032 reset_n low SHALL immediately force IDLE, busy=0, done=0, avm_read=0, avm_write=0, avm_chipselect=0, avm_address=0, avm_writedata=0, err_count=0, first_err_addr=0, outstanding=0.
REQ-033 Reset mid-run SHALL abandon the run without done; late readdatavalid after reset ignored per REQ-030.

Verification
REQ-034 FILL base=0x0010, count=4, seed=0xA0000000, waitrequest=0 -> writes 0xA0000000..0xA0000003 to 0x0010..0x0013 in 4 consecutive cycles, done 1 cycle after last.
REQ-035 CHECK same region, 1-cycle-latency slave model -> err_count=0, first_err_addr=0, done pulse once.
REQ-036 CHECK with word at 0x0012 corrupted to 0 -> err_count=1, first_err_addr=0x0012.
REQ-037 FILL base=0xFFFE, count=4, random waitrequest -> addresses 0xFFFE,0xFFFF,0x0000,0x0001, signals stable during stall, no dropped/duplicated writes.
REQ-038 CHECK count=20, slave latency 6 cycles -> outstanding never exceeds 4, 20 responses compared, done after last.
REQ-039 reset_n low mid-READ with 3 reads outstanding -> strobes drop immediately, busy=0, no done; new start count=0 -> done in cycle N+1.
